// File: rtl/serial_alu_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell walks LSB-first over WIDTH cycles.
// Optional zero/ovf flag outputs are enabled by defining SERIAL_FLAGS_EN.

module add1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_alu_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             sum_bit;
  logic             cell_co;
  logic             last;
`ifdef SERIAL_FLAGS_EN
  logic             nz_acc;
`endif

  add1bit u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (sum_bit),
    .co (cell_co)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Subtraction is A + ~B + 1: invert B at load and seed the carry with op_sub.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_FLAGS_EN
      nz_acc <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a_in;
            b_sh   <= op_sub ? ~b_in : b_in;
            carry  <= op_sub;
            cnt    <= '0;
            state  <= RUN;
`ifdef SERIAL_FLAGS_EN
            nz_acc <= 1'b0;
`endif
          end
        end
        RUN: begin
          result <= {sum_bit, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= cell_co;
          cnt    <= cnt + CNT_W'(1);
`ifdef SERIAL_FLAGS_EN
          nz_acc <= nz_acc | sum_bit;
`endif
          if (last) begin
            cout  <= cell_co;
            state <= DONE;
`ifdef SERIAL_FLAGS_EN
            // On the final step the carry flop holds the carry into the MSB.
            zero  <= ~(nz_acc | sum_bit);
            ovf   <= carry ^ cell_co;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_alu_ctrl.md
Name: serial_alu_ctrl

Overview:
- Bit-serial add/subtract controller for the eight-bit calculator.
- Sequences a single 1-bit full-adder cell (add1bit) over WIDTH clock cycles, LSB first, to produce a WIDTH-bit sum or difference.
- Sits between the calculator's operand/opcode front end and the result display register.
- Trades throughput for area: one adder cell, one carry flop, shift registers.

Parameters:
- WIDTH, 8, operand and result width in bits (min 2).
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request an operation; sampled only in IDLE.
- op_sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- a_in  input  WIDTH  operand A; sampled with start.
- b_in  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while operation in progress (RUN state).
- done  output  1  one-cycle pulse, result valid.
- result  output  WIDTH  sum/difference; held until next accepted start.
- cout  output  1  final carry out (for sub: 1 = no borrow, A >= B unsigned).

Behaviour:
- Reset (rst_n low at a rising edge):
  - state goes to IDLE.
  - busy, done, cout, result, carry flop, counter and shift registers all go to 0.
  - Reset mid-RUN aborts the operation; no done pulse, partial result discarded.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at edge E0: latch a_sh=a_in, b_sh=(op_sub ? ~b_in : b_in), carry=op_sub, cnt=0; go to RUN.
  - result and cout keep their previous values until the first RUN shift.
- RUN (edges E1..E_WIDTH):
  - The full-adder cell takes a_sh[0], b_sh[0], carry.
  - Sum bit shifts into result MSB; result shifts right.
  - a_sh and b_sh shift right; carry <= cell Cout; cnt++.
  - At edge E_WIDTH (cnt == WIDTH-1 before the edge): load cout <= cell Cout; go to DONE.
- DONE: done=1 for exactly one cycle; busy=0; next edge returns to IDLE.
- Timing:
  - busy is high for exactly WIDTH cycles, starting the cycle after E0.
  - done is high during the cycle following E_WIDTH, i.e. WIDTH+1 cycles after start was sampled.
- start while in RUN or DONE is ignored (no queueing); start held high re-triggers on the first IDLE cycle.
- op_sub, a_in and b_in changes after E0 have no effect.
- Arithmetic is modulo 2^WIDTH (wrap-around); cout carries the 2^WIDTH bit.
- busy and done are never high simultaneously.

Optional Feature:
- Macro SERIAL_FLAGS_EN.
- Defined:
  - Adds outputs zero (1 bit) and ovf (1 bit), both reset to 0.
  - Both update at E_WIDTH and hold until the next E_WIDTH.
  - zero=1 iff final result == 0; tracked as an OR of shifted sum bits, cleared at E0.
  - ovf = signed two's-complement overflow = (carry into MSB) XOR (carry out of MSB); the carry into the MSB is captured at edge E_WIDTH.
- Undefined: ports zero and ovf are absent; no extra logic.

Test Plan:
- Add 0x3C+0x05, op_sub=0, start pulse -> busy high 8 cycles; done at cycle 9 after start; result=0x41, cout=0.
- Add 0xFF+0x01 -> result=0x00, cout=1; with SERIAL_FLAGS_EN: zero=1, ovf=0.
- Sub 0x10-0x20 -> result=0xF0, cout=0 (borrow); sub 0x20-0x10 -> result=0x10, cout=1.
- Add 0x7F+0x01 with SERIAL_FLAGS_EN -> result=0x80, ovf=1, zero=0, cout=0.
- Start 0x01+0x01, then pulse start with 0xAA+0x55 at cycle 3 (busy) -> ignored; done once, result=0x02.
- Start 0xF0+0x0F, drive rst_n=0 at cycle 4 -> next cycle busy=0, result=0x00, cout=0, no done pulse; a new start afterwards completes normally.
